// File: rtl/usb_pulpino_byte_bridge_if.sv
// Host and PULPino-side signal bundle for the byte bridge.
// Signal names keep the bridge's _i/_o orientation; the slave modport is the bridge side.
interface usb_pulpino_byte_bridge_if #(
    parameter int unsigned pDEPTH      = 16,
    parameter int unsigned pDATA_WIDTH = 8
);
    localparam int unsigned CW = $clog2(pDEPTH) + 1;

    logic                   host_wr_i;
    logic [pDATA_WIDTH-1:0] host_wr_data_i;
    logic                   host_rd_i;
    logic [pDATA_WIDTH-1:0] host_rd_data_o;
    logic                   host_clr_i;
    logic [CW-1:0]          tx_level_o;
    logic [CW-1:0]          rx_level_o;
    logic                   tx_full_o;
    logic                   rx_empty_o;
    logic                   overflow_o;
    logic                   underflow_o;
    logic                   proto_err_o;
    logic [pDATA_WIDTH-1:0] pul_rx_data_o;
    logic                   pul_rx_flicker_o;
    logic                   pul_ack_flicker_i;
    logic [pDATA_WIDTH-1:0] pul_tx_data_i;
    logic                   pul_tx_flicker_i;
    logic                   pul_tx_ack_flicker_o;

    modport slave (
        input  host_wr_i, host_wr_data_i, host_rd_i, host_clr_i,
        input  pul_ack_flicker_i, pul_tx_data_i, pul_tx_flicker_i,
        output host_rd_data_o, tx_level_o, rx_level_o, tx_full_o, rx_empty_o,
        output overflow_o, underflow_o, proto_err_o,
        output pul_rx_data_o, pul_rx_flicker_o, pul_tx_ack_flicker_o
    );

    modport master (
        output host_wr_i, host_wr_data_i, host_rd_i, host_clr_i,
        output pul_ack_flicker_i, pul_tx_data_i, pul_tx_flicker_i,
        input  host_rd_data_o, tx_level_o, rx_level_o, tx_full_o, rx_empty_o,
        input  overflow_o, underflow_o, proto_err_o,
        input  pul_rx_data_o, pul_rx_flicker_o, pul_tx_ack_flicker_o
    );
endinterface

// File: rtl/usb_pulpino_byte_bridge.sv
// Buffered byte bridge: host strobed push/pop on one side, PULPino toggle handshake on the
// other, with one FIFO per direction and sticky misuse flags.
module usb_pulpino_byte_bridge #(
    parameter int unsigned pDEPTH      = 16,
    parameter int unsigned pDATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_i,
    usb_pulpino_byte_bridge_if.slave bus
);
    localparam int unsigned   AW       = $clog2(pDEPTH);
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] LVL_FULL = CW'(pDEPTH);

    localparam logic TX_IDLE     = 1'b0;
    localparam logic TX_WAIT_ACK = 1'b1;
    localparam logic RX_IDLE     = 1'b0;
    localparam logic RX_PENDING  = 1'b1;

    logic [pDATA_WIDTH-1:0] r_tx_mem [pDEPTH];
    logic [pDATA_WIDTH-1:0] r_rx_mem [pDEPTH];
    logic [AW-1:0]          r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [CW-1:0]          r_tx_level, r_rx_level;
    logic                   r_tx_state, r_rx_state;
    logic                   r_ack_prev, r_tx_prev;
    logic [pDATA_WIDTH-1:0] r_pul_rx_data;
    logic                   r_pul_rx_flicker;
    logic                   r_pul_tx_ack_flicker;
    logic [pDATA_WIDTH-1:0] r_pend_data;
    logic                   r_overflow, r_underflow, r_proto_err;

    logic                   w_ack_evt, w_tx_evt;
    logic                   w_tx_full, w_rx_full, w_rx_empty;
    logic                   w_tx_push, w_tx_launch, w_rx_pop;
    logic                   w_rx_push, w_pend_load, w_rx_state_d;
    logic [pDATA_WIDTH-1:0] w_rx_push_data;
    logic                   w_ovf_evt, w_udf_evt, w_proto_evt;

    assign w_ack_evt   = bus.pul_ack_flicker_i ^ r_ack_prev;
    assign w_tx_evt    = bus.pul_tx_flicker_i ^ r_tx_prev;
    assign w_tx_full   = (r_tx_level == LVL_FULL);
    assign w_rx_full   = (r_rx_level == LVL_FULL);
    assign w_rx_empty  = (r_rx_level == '0);
    assign w_tx_push   = bus.host_wr_i & ~w_tx_full;
    assign w_tx_launch = (r_tx_state == TX_IDLE) && (r_tx_level != '0);
    assign w_rx_pop    = bus.host_rd_i & ~w_rx_empty;

    assign w_ovf_evt   = bus.host_wr_i & w_tx_full;
    assign w_udf_evt   = bus.host_rd_i & w_rx_empty;
    assign w_proto_evt = (w_ack_evt && (r_tx_state == TX_IDLE)) ||
                         (w_tx_evt && (r_rx_state == RX_PENDING));

    // A toggle arriving while RX is full is parked in r_pend_data with its ack withheld.
    always_comb begin
        w_rx_push      = 1'b0;
        w_pend_load    = 1'b0;
        w_rx_push_data = bus.pul_tx_data_i;
        w_rx_state_d   = r_rx_state;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_tx_evt) begin
                    if (!w_rx_full) begin
                        w_rx_push = 1'b1;
                    end else begin
                        w_pend_load  = 1'b1;
                        w_rx_state_d = RX_PENDING;
                    end
                end
            end
            default: begin
                if (!w_rx_full) begin
                    w_rx_push      = 1'b1;
                    w_rx_push_data = r_pend_data;
                    w_rx_state_d   = RX_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.host_wr_data_i;
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= w_rx_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_tx_wptr            <= '0;
            r_tx_rptr            <= '0;
            r_rx_wptr            <= '0;
            r_rx_rptr            <= '0;
            r_tx_level           <= '0;
            r_rx_level           <= '0;
            r_tx_state           <= TX_IDLE;
            r_rx_state           <= RX_IDLE;
            r_ack_prev           <= 1'b0;
            r_tx_prev            <= 1'b0;
            r_pul_rx_data        <= '0;
            r_pul_rx_flicker     <= 1'b0;
            r_pul_tx_ack_flicker <= 1'b0;
            r_pend_data          <= '0;
            r_overflow           <= 1'b0;
            r_underflow          <= 1'b0;
            r_proto_err          <= 1'b0;
        end else begin
            r_ack_prev <= bus.pul_ack_flicker_i;
            r_tx_prev  <= bus.pul_tx_flicker_i;

            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_launch) begin
                r_tx_rptr        <= r_tx_rptr + 1'b1;
                r_pul_rx_data    <= r_tx_mem[r_tx_rptr];
                r_pul_rx_flicker <= ~r_pul_rx_flicker;
                r_tx_state       <= TX_WAIT_ACK;
            end else if ((r_tx_state == TX_WAIT_ACK) && w_ack_evt) begin
                r_tx_state <= TX_IDLE;
            end
            r_tx_level <= r_tx_level + CW'(w_tx_push) - CW'(w_tx_launch);

            if (w_rx_push) begin
                r_rx_wptr            <= r_rx_wptr + 1'b1;
                r_pul_tx_ack_flicker <= ~r_pul_tx_ack_flicker;
            end
            if (w_rx_pop) r_rx_rptr <= r_rx_rptr + 1'b1;
            if (w_pend_load) r_pend_data <= bus.pul_tx_data_i;
            r_rx_state <= w_rx_state_d;
            r_rx_level <= r_rx_level + CW'(w_rx_push) - CW'(w_rx_pop);

            // New error in the same cycle as a clear keeps the flag set.
            if (w_ovf_evt)           r_overflow  <= 1'b1;
            else if (bus.host_clr_i) r_overflow  <= 1'b0;
            if (w_udf_evt)           r_underflow <= 1'b1;
            else if (bus.host_clr_i) r_underflow <= 1'b0;
            if (w_proto_evt)         r_proto_err <= 1'b1;
            else if (bus.host_clr_i) r_proto_err <= 1'b0;
        end
    end

    assign bus.host_rd_data_o       = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
    assign bus.tx_level_o           = r_tx_level;
    assign bus.rx_level_o           = r_rx_level;
    assign bus.tx_full_o            = w_tx_full;
    assign bus.rx_empty_o           = w_rx_empty;
    assign bus.overflow_o           = r_overflow;
    assign bus.underflow_o          = r_underflow;
    assign bus.proto_err_o          = r_proto_err;
    assign bus.pul_rx_data_o        = r_pul_rx_data;
    assign bus.pul_rx_flicker_o     = r_pul_rx_flicker;
    assign bus.pul_tx_ack_flicker_o = r_pul_tx_ack_flicker;
endmodule

// File: tb/tb_usb_pulpino_byte_bridge.sv
// Directed bench for usb_pulpino_byte_bridge with byte scoreboards per direction.
module tb_usb_pulpino_byte_bridge;
    logic clk = 1'b0;
    logic reset_i;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       last_fl;
    logic       ack_f;
    logic       tx_f;
    logic       exp_ack;

    usb_pulpino_byte_bridge_if #(.pDEPTH(16), .pDATA_WIDTH(8)) bus ();

    usb_pulpino_byte_bridge #(.pDEPTH(16), .pDATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for each launch toggle, score the byte, optionally confirm it holds without ack, then ack.
    task automatic serve_tx(input int n, input bit hold_chk);
        for (int i = 0; i < n; i++) begin
            int         w = 0;
            logic [7:0] e;
            while ((bus.pul_rx_flicker_o === last_fl) && (w < 20)) begin
                tick();
                w++;
            end
            if (w >= 20) begin
                chk("tx_launch_timeout", {31'd0, bus.pul_rx_flicker_o}, {31'd0, ~last_fl});
                return;
            end
            e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
            chk("tx_byte", {24'd0, bus.pul_rx_data_o}, (tx_q.size() >= 0) ? {24'd0, e} : 32'hdead);
            last_fl = bus.pul_rx_flicker_o;
            if (hold_chk) begin
                repeat (3) tick();
                chk("tx_hold_no_ack", {31'd0, bus.pul_rx_flicker_o}, {31'd0, last_fl});
            end
            ack_f                 = ~ack_f;
            bus.pul_ack_flicker_i = ack_f;
            tick();
        end
    endtask

    task automatic host_write(input logic [7:0] d);
        bus.host_wr_i      = 1'b1;
        bus.host_wr_data_i = d;
        tick();
        bus.host_wr_i      = 1'b0;
    endtask

    initial begin
        reset_i               = 1'b1;
        bus.host_wr_i         = 1'b0;
        bus.host_wr_data_i    = '0;
        bus.host_rd_i         = 1'b0;
        bus.host_clr_i        = 1'b0;
        bus.pul_ack_flicker_i = 1'b0;
        bus.pul_tx_data_i     = '0;
        bus.pul_tx_flicker_i  = 1'b0;
        ack_f   = 1'b0;
        tx_f    = 1'b0;
        last_fl = 1'b0;
        exp_ack = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;

        // Reset state
        chk("rst_tx_level", {28'd0, bus.tx_level_o}, 32'd0);
        chk("rst_rx_level", {28'd0, bus.rx_level_o}, 32'd0);
        chk("rst_rx_empty", {31'd0, bus.rx_empty_o}, 32'd1);
        chk("rst_flags", {29'd0, bus.overflow_o, bus.underflow_o, bus.proto_err_o}, 32'd0);
        chk("rst_flickers", {30'd0, bus.pul_rx_flicker_o, bus.pul_tx_ack_flicker_o}, 32'd0);
        chk("rst_rd_data", {24'd0, bus.host_rd_data_o}, 32'd0);

        // 1: single byte latency
        host_write(8'hA5);
        tx_q.push_back(8'hA5);
        chk("t1_level_n", {28'd0, bus.tx_level_o}, 32'd1);
        chk("t1_flicker_n", {31'd0, bus.pul_rx_flicker_o}, 32'd0);
        tick();
        chk("t1_level_n1", {28'd0, bus.tx_level_o}, 32'd0);
        chk("t1_flicker_n1", {31'd0, bus.pul_rx_flicker_o}, 32'd1);
        serve_tx(1, 1'b0);

        // 2: back-to-back writes, each launch waits for the previous ack
        for (int k = 1; k <= 3; k++) begin
            host_write(8'(k));
            tx_q.push_back(8'(k));
        end
        serve_tx(3, 1'b1);
        tick();
        chk("t2_level_done", {28'd0, bus.tx_level_o}, 32'd0);
        chk("t2_no_proto", {31'd0, bus.proto_err_o}, 32'd0);

        // 3: PULPino sends 17 bytes into a 16-deep RX FIFO
        for (int k = 0; k < 17; k++) begin
            tx_f                 = ~tx_f;
            bus.pul_tx_flicker_i = tx_f;
            bus.pul_tx_data_i    = 8'(8'h40 + k);
            rx_q.push_back(8'(8'h40 + k));
            if (k < 16) exp_ack = ~exp_ack;
            tick();
            chk("t3_ack", {31'd0, bus.pul_tx_ack_flicker_o}, {31'd0, exp_ack});
        end
        chk("t3_rx_level_full", {28'd0, bus.rx_level_o}, 32'd16);
        chk("t3_no_proto", {31'd0, bus.proto_err_o}, 32'd0);
        chk("t3_head", {24'd0, bus.host_rd_data_o}, {24'd0, rx_q.pop_front()});
        bus.host_rd_i = 1'b1;
        tick();
        bus.host_rd_i = 1'b0;
        chk("t3_level_after_rd", {28'd0, bus.rx_level_o}, 32'd15);
        chk("t3_ack_still_held", {31'd0, bus.pul_tx_ack_flicker_o}, {31'd0, exp_ack});
        tick();
        exp_ack = ~exp_ack;
        chk("t3_level_pend_push", {28'd0, bus.rx_level_o}, 32'd16);
        chk("t3_ack_pend_push", {31'd0, bus.pul_tx_ack_flicker_o}, {31'd0, exp_ack});
        while (rx_q.size() != 0) begin
            chk("t3_drain", {24'd0, bus.host_rd_data_o}, {24'd0, rx_q.pop_front()});
            bus.host_rd_i = 1'b1;
            tick();
            bus.host_rd_i = 1'b0;
        end
        chk("t3_rx_empty", {31'd0, bus.rx_empty_o}, 32'd1);
        chk("t3_no_underflow", {31'd0, bus.underflow_o}, 32'd0);

        // 4: fill TX with no acks, then overflow
        for (int k = 0; k < 18; k++) begin
            bus.host_wr_i      = 1'b1;
            bus.host_wr_data_i = 8'(8'h80 + k);
            if (k < 17) tx_q.push_back(8'(8'h80 + k));
            tick();
            if (k == 16) begin
                chk("t4_level_17th", {28'd0, bus.tx_level_o}, 32'd16);
                chk("t4_no_ovf_yet", {31'd0, bus.overflow_o}, 32'd0);
            end
        end
        bus.host_wr_i = 1'b0;
        chk("t4_overflow", {31'd0, bus.overflow_o}, 32'd1);
        chk("t4_full", {31'd0, bus.tx_full_o}, 32'd1);
        chk("t4_level_kept", {28'd0, bus.tx_level_o}, 32'd16);
        bus.host_clr_i = 1'b1;
        tick();
        bus.host_clr_i = 1'b0;
        chk("t4_clr", {31'd0, bus.overflow_o}, 32'd0);
        serve_tx(17, 1'b0);
        repeat (2) tick();
        chk("t4_dropped_not_sent", {31'd0, bus.pul_rx_flicker_o}, {31'd0, last_fl});
        chk("t4_level_done", {28'd0, bus.tx_level_o}, 32'd0);

        // 5: underflow, stray ack, clear racing a new error
        bus.host_rd_i = 1'b1;
        tick();
        bus.host_rd_i = 1'b0;
        chk("t5_underflow", {31'd0, bus.underflow_o}, 32'd1);
        chk("t5_rd_data_zero", {24'd0, bus.host_rd_data_o}, 32'd0);
        chk("t5_rx_level", {28'd0, bus.rx_level_o}, 32'd0);
        ack_f                 = ~ack_f;
        bus.pul_ack_flicker_i = ack_f;
        tick();
        chk("t5_proto_err", {31'd0, bus.proto_err_o}, 32'd1);
        chk("t5_no_launch", {31'd0, bus.pul_rx_flicker_o}, {31'd0, last_fl});
        bus.host_clr_i = 1'b1;
        bus.host_rd_i  = 1'b1;
        tick();
        bus.host_rd_i  = 1'b0;
        chk("t5_err_wins_clr", {31'd0, bus.underflow_o}, 32'd1);
        chk("t5_proto_cleared", {31'd0, bus.proto_err_o}, 32'd0);
        tick();
        bus.host_clr_i = 1'b0;
        chk("t5_underflow_cleared", {31'd0, bus.underflow_o}, 32'd0);

        // 6: reset while waiting for ack with 5 queued
        for (int k = 0; k < 6; k++) host_write(8'(8'hC0 + k));
        chk("t6_level_queued", {28'd0, bus.tx_level_o}, 32'd5);
        chk("t6_launched", {31'd0, bus.pul_rx_flicker_o}, {31'd0, ~last_fl});
        tx_q.delete();
        reset_i               = 1'b1;
        ack_f                 = 1'b0;
        tx_f                  = 1'b0;
        bus.pul_ack_flicker_i = 1'b0;
        bus.pul_tx_flicker_i  = 1'b0;
        tick();
        reset_i = 1'b0;
        last_fl = 1'b0;
        exp_ack = 1'b0;
        chk("t6_levels", {24'd0, bus.tx_level_o, bus.rx_level_o}, 32'd0);
        chk("t6_flickers", {30'd0, bus.pul_rx_flicker_o, bus.pul_tx_ack_flicker_o}, 32'd0);
        chk("t6_data", {24'd0, bus.pul_rx_data_o}, 32'd0);
        host_write(8'h5A);
        tick();
        chk("t6_relaunch_flicker", {31'd0, bus.pul_rx_flicker_o}, 32'd1);
        chk("t6_relaunch_data", {24'd0, bus.pul_rx_data_o}, 32'h5A);
        tx_f                 = 1'b1;
        bus.pul_tx_flicker_i = 1'b1;
        bus.pul_tx_data_i    = 8'h33;
        tick();
        chk("t6_rx_ack", {31'd0, bus.pul_tx_ack_flicker_o}, 32'd1);
        chk("t6_rx_head", {24'd0, bus.host_rd_data_o}, 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
